// File: rtl/ct_clint_apb_arb_if.sv
// APB bus between the two-requester arbiter and the CLINT slave.
// The arbiter drives the request phase and the slave returns data, ready and error.
interface ct_clint_apb_arb_if;
   logic        psel_clint;
   logic        penable;
   logic [31:0] paddr;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [1:0]  pprot;
   logic [31:0] prdata_clint;
   logic        pready_clint;
   logic        perr_clint;

   modport master (
      output psel_clint, penable, paddr, pwrite, pwdata, pprot,
      input  prdata_clint, pready_clint, perr_clint
   );

   modport slave (
      input  psel_clint, penable, paddr, pwrite, pwdata, pprot,
      output prdata_clint, pready_clint, perr_clint
   );
endinterface

// File: rtl/ct_clint_apb_arb.sv
// Two-requester round-robin arbiter in front of the CLINT APB slave.
// Runs one APB transfer at a time (IDLE -> SETUP -> ACCESS). A wait-state
// watchdog forces an error completion after TIMEOUT stalled ACCESS cycles.
// All state advances only on edges where apb_clk_en is high; the done
// pulse is the exception and always clears on the following clock edge.
module ct_clint_apb_arb #(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic                  forever_apbclk,
   input  logic                  cpurst_b,
   input  logic                  apb_clk_en,
   input  logic                  req0_vld,
   input  logic                  req0_write,
   input  logic [31:0]           req0_addr,
   input  logic [31:0]           req0_wdata,
   input  logic [1:0]            req0_prot,
   input  logic                  req1_vld,
   input  logic                  req1_write,
   input  logic [31:0]           req1_addr,
   input  logic [31:0]           req1_wdata,
   input  logic [1:0]            req1_prot,
   output logic                  req0_done,
   output logic [31:0]           req0_rdata,
   output logic                  req0_err,
   output logic                  req1_done,
   output logic [31:0]           req1_rdata,
   output logic                  req1_err,
   output logic                  arb_busy,
   output logic                  arb_gnt_id,
   ct_clint_apb_arb_if.master    apb
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t      state_r, state_s;
   logic [7:0]  cnt_r, cnt_s;
   logic        last_r, last_s;
   logic        gnt_r, gnt_s;
   logic        busy_r, busy_s;
   logic        psel_r, psel_s;
   logic        penable_r, penable_s;
   logic [31:0] paddr_r, paddr_s;
   logic        pwrite_r, pwrite_s;
   logic [31:0] pwdata_r, pwdata_s;
   logic [1:0]  pprot_r, pprot_s;
   logic [1:0]  done_r, done_s;
   logic [1:0]  err_r, err_s;
   logic [31:0] rdata0_r, rdata0_s;
   logic [31:0] rdata1_r, rdata1_s;
   logic [1:0]  mask_s;
   logic        win_s;
   logic        cpl_s;
   logic        cpl_err_s;
   logic [31:0] cpl_rdata_s;

   // Next-state, arbitration and completion decode; everything holds unless enabled.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      last_s      = last_r;
      gnt_s       = gnt_r;
      psel_s      = psel_r;
      penable_s   = penable_r;
      paddr_s     = paddr_r;
      pwrite_s    = pwrite_r;
      pwdata_s    = pwdata_r;
      pprot_s     = pprot_r;
      err_s       = err_r;
      rdata0_s    = rdata0_r;
      rdata1_s    = rdata1_r;
      done_s      = 2'b00;
      cpl_s       = 1'b0;
      cpl_err_s   = 1'b0;
      cpl_rdata_s = 32'h0000_0000;
      // A requester is never re-granted in the cycle its done pulse is high.
      mask_s      = {req1_vld & ~done_r[1], req0_vld & ~done_r[0]};

      if (mask_s == 2'b11) begin
         win_s = ~last_r;
      end else if (mask_s[1]) begin
         win_s = 1'b1;
      end else begin
         win_s = 1'b0;
      end

      if (apb_clk_en) begin
         case (state_r)
            ST_IDLE: begin
               if (mask_s != 2'b00) begin
                  state_s  = ST_SETUP;
                  psel_s   = 1'b1;
                  gnt_s    = win_s;
                  last_s   = win_s;
                  paddr_s  = win_s ? req1_addr  : req0_addr;
                  pwrite_s = win_s ? req1_write : req0_write;
                  pwdata_s = win_s ? req1_wdata : req0_wdata;
                  pprot_s  = win_s ? req1_prot  : req0_prot;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_SETUP: begin
               state_s   = ST_ACCESS;
               penable_s = 1'b1;
               cnt_s     = 8'd0;
            end
            ST_ACCESS: begin
               // Slave ready wins over the watchdog on the same edge.
               if (apb.pready_clint) begin
                  cpl_s       = 1'b1;
                  cpl_err_s   = apb.perr_clint;
                  cpl_rdata_s = pwrite_r ? 32'h0000_0000 : apb.prdata_clint;
               end else if (cnt_r == TIMEOUT) begin
                  cpl_s       = 1'b1;
                  cpl_err_s   = 1'b1;
                  cpl_rdata_s = 32'h0000_0000;
               end else begin
                  cnt_s = cnt_r + 8'd1;
               end
            end
            default: begin
               state_s   = ST_IDLE;
               psel_s    = 1'b0;
               penable_s = 1'b0;
            end
         endcase
      end else begin
         state_s = state_r;
      end

      if (cpl_s) begin
         state_s   = ST_IDLE;
         psel_s    = 1'b0;
         penable_s = 1'b0;
         if (gnt_r) begin
            done_s[1] = 1'b1;
            err_s[1]  = cpl_err_s;
            rdata1_s  = cpl_rdata_s;
         end else begin
            done_s[0] = 1'b1;
            err_s[0]  = cpl_err_s;
            rdata0_s  = cpl_rdata_s;
         end
      end else begin
         done_s = 2'b00;
      end

      busy_s = (state_s != ST_IDLE);
   end

   // State and output registers; reset restores idle with req0 favoured on the first tie.
   always_ff @(posedge forever_apbclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_r   <= ST_IDLE;
         cnt_r     <= 8'd0;
         last_r    <= 1'b1;
         gnt_r     <= 1'b0;
         busy_r    <= 1'b0;
         psel_r    <= 1'b0;
         penable_r <= 1'b0;
         paddr_r   <= 32'h0000_0000;
         pwrite_r  <= 1'b0;
         pwdata_r  <= 32'h0000_0000;
         pprot_r   <= 2'b00;
         done_r    <= 2'b00;
         err_r     <= 2'b00;
         rdata0_r  <= 32'h0000_0000;
         rdata1_r  <= 32'h0000_0000;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         last_r    <= last_s;
         gnt_r     <= gnt_s;
         busy_r    <= busy_s;
         psel_r    <= psel_s;
         penable_r <= penable_s;
         paddr_r   <= paddr_s;
         pwrite_r  <= pwrite_s;
         pwdata_r  <= pwdata_s;
         pprot_r   <= pprot_s;
         done_r    <= done_s;
         err_r     <= err_s;
         rdata0_r  <= rdata0_s;
         rdata1_r  <= rdata1_s;
      end
   end

   assign apb.psel_clint = psel_r;
   assign apb.penable    = penable_r;
   assign apb.paddr      = paddr_r;
   assign apb.pwrite     = pwrite_r;
   assign apb.pwdata     = pwdata_r;
   assign apb.pprot      = pprot_r;
   assign req0_done      = done_r[0];
   assign req1_done      = done_r[1];
   assign req0_err       = err_r[0];
   assign req1_err       = err_r[1];
   assign req0_rdata     = rdata0_r;
   assign req1_rdata     = rdata1_r;
   assign arb_busy       = busy_r;
   assign arb_gnt_id     = gnt_r;

endmodule

// File: doc/ct_clint_apb_arb.md
CT_CLINT_APB_ARB -- requirements
Module: ct_clint_apb_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8'd255, max wait-state cycles in ACCESS before forced error completion.
REQ-002 SHALL have forever_apbclk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have cpurst_b  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have apb_clk_en  input  1  APB clock enable; FSM, counter and pointer advance only on edges where it is 1.
REQ-005 SHALL have, for N in {0,1}: reqN_vld input 1 request; reqN_write input 1; reqN_addr input 32; reqN_wdata input 32; reqN_prot input 2.
REQ-006 SHALL have, for N in {0,1}: reqN_done output 1 one-cycle completion pulse; reqN_rdata output 32; reqN_err output 1.
REQ-007 SHALL have APB master outputs psel_clint 1, penable 1, paddr 32, pwrite 1, pwdata 32, pprot 2, driving the CLINT slave.
REQ-008 SHALL have APB slave-response inputs prdata_clint 32, pready_clint 1, perr_clint 1.
REQ-009 SHALL have arb_busy output 1 (state != IDLE) and arb_gnt_id output 1 (requester currently owning the bus).

Function
REQ-010 SHALL implement FSM states IDLE, SETUP, ACCESS; all transitions qualified by apb_clk_en.
REQ-011 IDLE: if any masked request valid -> latch winner's addr/write/wdata/prot into paddr/pwrite/pwdata/pprot, set arb_gnt_id, psel_clint=1, go SETUP.
REQ-012 Masked request: reqN_vld & ~reqN_done (a requester is not re-granted in its done cycle).
REQ-013 Arbitration SHALL be round-robin: single request wins; both valid -> the requester not granted last wins; last-grant pointer updates on each grant.
REQ-014 SETUP -> ACCESS unconditionally on next enabled edge, penable=1; wait counter cleared to 0.
REQ-015 ACCESS, pready_clint=1: go IDLE, psel_clint=0, penable=0, reqN_done=1 for granted N, reqN_rdata=prdata_clint when pwrite=0 else 0, reqN_err=perr_clint.
REQ-016 ACCESS, pready_clint=0, counter<TIMEOUT: stay, counter +1 (8-bit, no wrap possible).
REQ-017 ACCESS, pready_clint=0, counter==TIMEOUT: complete as REQ-015 with reqN_err=1, reqN_rdata=0.
REQ-018 pready_clint=1 on the timeout cycle SHALL take precedence (normal completion).
REQ-019 paddr/pwrite/pwdata/pprot SHALL be stable from SETUP through completion; requesters hold fields until reqN_done.
REQ-020 reqN_done SHALL be high exactly one forever_apbclk cycle, independent of apb_clk_en; reqN_rdata/reqN_err hold until that requester's next completion.
REQ-021 Minimum transaction: grant edge to done pulse = 3 enabled edges (IDLE->SETUP->ACCESS->IDLE with pready=1).
REQ-022 Edges with apb_clk_en=0 SHALL change no state, outputs or counter, except reqN_done clearing.
REQ-023 reqN_vld dropped mid-transaction SHALL NOT abort it; completion still pulses reqN_done.

Reset
REQ-024 cpurst_b=0 SHALL immediately force: state IDLE, psel_clint=0, penable=0, paddr=0, pwrite=0, pwdata=0, pprot=0, reqN_done=0, reqN_rdata=0, reqN_err=0, arb_busy=0, arb_gnt_id=0, counter=0, last-grant pointer=1 (req0 wins first tie).
REQ-025 Reset mid-transaction SHALL drop psel_clint/penable asynchronously; no done pulse issued for the aborted transfer.

Verification
REQ-026 Single read: req0 read addr 0x0400_4000, pready=1 in first ACCESS, prdata=0x1234_5678 -> req0_done on 3rd enabled edge, req0_rdata=0x1234_5678, req0_err=0.
REQ-027 Tie: req0 and req1 both valid from reset -> req0 granted first, then req1; next tie -> req0 again (alternation).
REQ-028 Wait states: pready low 5 ACCESS cycles, apb_clk_en toggling 1/0 -> completion after 5 enabled waits, psel/penable/paddr stable throughout.
REQ-029 Timeout: TIMEOUT=4, pready held 0 -> error completion after 4 wait increments plus 1, reqN_err=1, rdata=0; pready=1 on that edge -> normal completion.
REQ-030 Write with perr_clint=1: req1 write wdata 0xDEAD_BEEF -> pwdata=0xDEAD_BEEF, pwrite=1, req1_err=1, req1_rdata=0.
REQ-031 Reset in ACCESS: cpurst_b low -> psel_clint/penable 0 same cycle, no done pulse; after release, req0 wins first tie.
